// File: rtl/viterbi_ber_checker_if.sv
// viterbi_ber_checker_if
//
// Groups the sample strobe, measurement control and result signals of the
// Viterbi bit-error checker into one bundle.
//   master : drives enable_i/ref_i/dut_i/start_i/lat_i/check_len_i and
//            observes the results (bench or surrounding tx/rx top)
//   slave  : the checker itself
// Ports carried:
//   enable_i, ref_i, dut_i      sample strobe, encoder-input bit, decoder-output bit
//   start_i, lat_i, check_len_i measurement start pulse, latency, window length
//   busy_o, done_o              status (FILL/CHECK, DONE)
//   good_o, bad_o, first_err_o  result counters and first error index
//   mismatch_o                  one-cycle pulse per mismatching compare
interface viterbi_ber_checker_if #(
    parameter int MAX_LAT = 64,
    parameter int CNT_W   = 16
);
    localparam int LAT_W = $clog2(MAX_LAT);

    logic             enable_i;
    logic             ref_i;
    logic             dut_i;
    logic             start_i;
    logic [LAT_W-1:0] lat_i;
    logic [CNT_W-1:0] check_len_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] good_o;
    logic [CNT_W-1:0] bad_o;
    logic [CNT_W-1:0] first_err_o;
    logic             mismatch_o;

    modport master (
        output enable_i, ref_i, dut_i, start_i, lat_i, check_len_i,
        input  busy_o, done_o, good_o, bad_o, first_err_o, mismatch_o
    );

    modport slave (
        input  enable_i, ref_i, dut_i, start_i, lat_i, check_len_i,
        output busy_o, done_o, good_o, bad_o, first_err_o, mismatch_o
    );
endinterface

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
//
// Bit-error scoreboard for the encode / channel / Viterbi-decode chain.
// The encoder input bit is pushed through a run-time-programmable delay line
// so it lines up with the decoder output; matching and mismatching samples
// are counted over a programmable window and the index of the first error
// is kept.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any measurement
//   bus  : viterbi_ber_checker_if.slave (strobe, data, control, results)
module viterbi_ber_checker #(
    parameter  int MAX_LAT = 64,
    parameter  int CNT_W   = 16,
    localparam int LAT_W   = $clog2(MAX_LAT)
) (
    input  logic                   clk,
    input  logic                   rst,
    viterbi_ber_checker_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

    state_t             state;
    state_t             state_nxt;

    logic [MAX_LAT-1:0] delay_line;
    logic [LAT_W-1:0]   lat_q;
    logic [LAT_W-1:0]   wp;
    logic [LAT_W-1:0]   fill_cnt;
    logic [LAT_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cmp_idx;
    logic [CNT_W-1:0]   good_q;
    logic [CNT_W-1:0]   bad_q;
    logic [CNT_W-1:0]   first_err_q;
    logic               mismatch_q;

    logic               start_ok;
    logic               sample_en;
    logic               cmp_en;
    logic               ref_bit;
    logic               bit_err;
    logic               last_cmp;
    logic               fill_last;

    // Qualifiers and the aligned reference bit. The read address is formed
    // from wp before this cycle's write, so slot wp-lat holds sample s-lat.
    // Latency zero would read a stale slot, hence the bypass to ref_i.
    always_comb begin
        start_ok  = bus.start_i && ((state == IDLE) || (state == DONE));
        sample_en = bus.enable_i && ((state == FILL) || (state == CHECK));
        cmp_en    = bus.enable_i && (state == CHECK);
        rd_addr   = wp - lat_q;
        ref_bit   = (lat_q == '0) ? bus.ref_i : delay_line[rd_addr];
        bit_err   = ref_bit ^ bus.dut_i;
        last_cmp  = (cmp_idx == (len_q - CNT_W'(1)));
        fill_last = (fill_cnt == (lat_q - LAT_W'(1)));
    end

    // Next-state logic. An empty window wins over a zero latency on start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    if (bus.check_len_i == '0)
                        state_nxt = DONE;
                    else if (bus.lat_i == '0)
                        state_nxt = CHECK;
                    else
                        state_nxt = FILL;
                end
            end
            FILL: begin
                if (bus.enable_i && fill_last)
                    state_nxt = CHECK;
            end
            CHECK: begin
                if (bus.enable_i && last_cmp)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Reference history. Deliberately not reset: only slots written during
    // the current measurement are ever read.
    always_ff @(posedge clk) begin
        if (sample_en)
            delay_line[wp] <= bus.ref_i;
    end

    // Measurement datapath: capture on start, fill counting, compare counters
    // and the registered mismatch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q       <= '0;
            len_q       <= '0;
            wp          <= '0;
            fill_cnt    <= '0;
            cmp_idx     <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            first_err_q <= '1;
            mismatch_q  <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            if (start_ok) begin
                lat_q       <= bus.lat_i;
                len_q       <= bus.check_len_i;
                wp          <= '0;
                fill_cnt    <= '0;
                cmp_idx     <= '0;
                good_q      <= '0;
                bad_q       <= '0;
                first_err_q <= '1;
            end else begin
                if (sample_en)
                    wp <= wp + LAT_W'(1);
                if (bus.enable_i && (state == FILL))
                    fill_cnt <= fill_cnt + LAT_W'(1);
                if (cmp_en) begin
                    cmp_idx <= cmp_idx + CNT_W'(1);
                    if (bit_err) begin
                        bad_q      <= bad_q + CNT_W'(1);
                        mismatch_q <= 1'b1;
                        if (first_err_q == '1)
                            first_err_q <= cmp_idx;
                    end else begin
                        good_q <= good_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.busy_o      = (state == FILL) || (state == CHECK);
    assign bus.done_o      = (state == DONE);
    assign bus.good_o      = good_q;
    assign bus.bad_o       = bad_q;
    assign bus.first_err_o = first_err_q;
    assign bus.mismatch_o  = mismatch_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker
//
// Self-checking bench for viterbi_ber_checker. Each measurement builds a
// random reference stream and a delayed (optionally corrupted) decoder
// stream, computes the expected counts and timing from plain arrays, pushes
// them to a scoreboard queue and compares them when the DUT reports done.
module tb_viterbi_ber_checker;

    localparam int MAX_LAT = 64;
    localparam int CNT_W   = 16;
    localparam int LAT_W   = $clog2(MAX_LAT);
    localparam int NO_ERR  = 65535;

    typedef struct {
        int good;
        int bad;
        int first_err;
        int done_cyc;
        int pulse_cyc;
    } result_t;

    logic    clk = 1'b0;
    logic    rst;
    result_t sb_q[$];
    bit      ref_arr[512];
    bit      dut_arr[512];
    int      compared   = 0;
    int      mismatched = 0;

    viterbi_ber_checker_if #(.MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) bus ();

    viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Every comparison of the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Edge (counted from the start edge) on which sample s is clocked in.
    function automatic int sampleEdge(input int s, input bit gap);
        return gap ? (2 * s + 1) : (s + 1);
    endfunction

    // Runs one full measurement: builds streams, pushes the expected result,
    // drives the start pulse and samples, then pops and checks the result.
    task automatic applyStimulus(input int lat, input int len, input int delay,
                                 input int flip, input bit gap, input bit mid_start);
        result_t expv;
        result_t got;
        int total;
        int s;
        int e_idx;
        int cyc;
        int pulses;

        total = (len == 0) ? 0 : lat + len;
        for (int i = 0; i < total; i++) begin
            ref_arr[i] = 1'($urandom());
        end
        for (int i = 0; i < total; i++) begin
            dut_arr[i] = (i >= delay) ? ref_arr[i - delay] : 1'($urandom());
        end
        if (flip >= 0)
            dut_arr[flip + lat] = ~dut_arr[flip + lat];

        expv.good      = 0;
        expv.bad       = 0;
        expv.first_err = NO_ERR;
        expv.pulse_cyc = -1;
        for (int k = 0; k < len; k++) begin
            if (dut_arr[k + lat] == ref_arr[k]) begin
                expv.good++;
            end else begin
                expv.bad++;
                if (expv.first_err == NO_ERR) begin
                    expv.first_err = k;
                    expv.pulse_cyc = sampleEdge(k + lat, gap) + 1;
                end
            end
        end
        expv.done_cyc = (total == 0) ? 1 : sampleEdge(total - 1, gap) + 1;
        sb_q.push_back(expv);

        // Start cycle, with a strobe that must be ignored.
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.lat_i       = LAT_W'(lat);
        bus.check_len_i = CNT_W'(len);
        bus.enable_i    = 1'b1;
        bus.ref_i       = 1'($urandom());
        bus.dut_i       = 1'($urandom());
        @(posedge clk);
        #1;
        cyc       = 1;
        got.done_cyc  = bus.done_o ? 1 : -1;
        got.pulse_cyc = -1;
        pulses    = 0;
        if (total > 0)
            checkOutput($sformatf("busy_after_start_lat%0d", lat), 32'(bus.busy_o), 1);

        s     = 0;
        e_idx = 0;
        while (s < total || (got.done_cyc < 0 && cyc < expv.done_cyc + 20)) begin
            e_idx++;
            @(negedge clk);
            bus.start_i  = 1'b0;
            bus.enable_i = 1'b0;
            bus.ref_i    = 1'($urandom());
            bus.dut_i    = 1'($urandom());
            if (s < total && (!gap || (e_idx % 2 == 1))) begin
                bus.enable_i = 1'b1;
                bus.ref_i    = ref_arr[s];
                bus.dut_i    = dut_arr[s];
                if (mid_start && s == lat + len / 2) begin
                    bus.start_i     = 1'b1;
                    bus.lat_i       = LAT_W'(1);
                    bus.check_len_i = CNT_W'(3);
                end
                s++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done_o && got.done_cyc < 0)
                got.done_cyc = cyc;
            if (bus.mismatch_o) begin
                pulses++;
                if (got.pulse_cyc < 0)
                    got.pulse_cyc = cyc;
            end
        end
        bus.enable_i = 1'b0;

        expv = sb_q.pop_front();
        checkOutput($sformatf("good_lat%0d_len%0d", lat, len), 32'(bus.good_o), expv.good);
        checkOutput($sformatf("bad_lat%0d_len%0d", lat, len), 32'(bus.bad_o), expv.bad);
        checkOutput($sformatf("first_err_lat%0d_len%0d", lat, len), 32'(bus.first_err_o), expv.first_err);
        checkOutput($sformatf("done_cycle_lat%0d_len%0d", lat, len), got.done_cyc, expv.done_cyc);
        checkOutput($sformatf("pulse_count_lat%0d_len%0d", lat, len), pulses, expv.bad);
        checkOutput($sformatf("first_pulse_cycle_lat%0d_len%0d", lat, len), got.pulse_cyc, expv.pulse_cyc);
        checkOutput($sformatf("busy_at_done_lat%0d_len%0d", lat, len), 32'(bus.busy_o), 0);
    endtask

    // Hard stop in case the DUT or bench wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.enable_i    = 1'b0;
        bus.ref_i       = 1'b0;
        bus.dut_i       = 1'b0;
        bus.start_i     = 1'b0;
        bus.lat_i       = '0;
        bus.check_len_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(bus.busy_o), 0);
        checkOutput("reset_done", 32'(bus.done_o), 0);
        checkOutput("reset_good", 32'(bus.good_o), 0);
        checkOutput("reset_bad", 32'(bus.bad_o), 0);
        checkOutput("reset_first_err", 32'(bus.first_err_o), NO_ERR);
        checkOutput("reset_mismatch", 32'(bus.mismatch_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean stream, then one flipped bit at compare index 37.
        applyStimulus(5, 100, 5, -1, 1'b0, 1'b0);
        applyStimulus(5, 100, 5, 37, 1'b0, 1'b0);
        // Latency programmed one short of the real decoder delay.
        applyStimulus(4, 200, 5, -1, 1'b0, 1'b0);
        // Bypass path and an empty window.
        applyStimulus(0, 10, 0, -1, 1'b0, 1'b0);
        applyStimulus(3, 0, 3, -1, 1'b0, 1'b0);
        // Sparse strobe, then sparse strobe with a start pulse mid-CHECK.
        applyStimulus(5, 100, 5, -1, 1'b1, 1'b0);
        applyStimulus(5, 100, 5, 20, 1'b1, 1'b1);

        // Abort a measurement mid-CHECK with a one-cycle reset.
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.lat_i       = LAT_W'(5);
        bus.check_len_i = CNT_W'(100);
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start_i  = 1'b0;
            bus.enable_i = 1'b1;
            bus.ref_i    = 1'($urandom());
            bus.dut_i    = 1'($urandom());
            @(posedge clk);
        end
        #1;
        checkOutput("busy_before_rst", 32'(bus.busy_o), 1);
        @(negedge clk);
        bus.enable_i = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_busy", 32'(bus.busy_o), 0);
        checkOutput("midrst_done", 32'(bus.done_o), 0);
        checkOutput("midrst_good", 32'(bus.good_o), 0);
        checkOutput("midrst_bad", 32'(bus.bad_o), 0);
        checkOutput("midrst_first_err", 32'(bus.first_err_o), NO_ERR);
        checkOutput("midrst_mismatch", 32'(bus.mismatch_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Maximum latency exercises delay-line wrap-around.
        applyStimulus(MAX_LAT - 1, 50, MAX_LAT - 1, -1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
